// File: rtl/freq_gate_counter.sv
// ---------------------------------------------------------------------------
// freq_gate_counter
//   Measures the frequency of an asynchronous input by counting its rising
//   edges over back-to-back gate windows of GATE_CYCLES clk cycles. At the
//   end of each window the edge count is latched onto 'counter', which feeds
//   the display stage directly and stays stable for a whole window.
//
// Ports
//   clk      in   1      system clock, all logic on posedge
//   rst      in   1      asynchronous reset, active low
//   enable   in   1      1 = measure continuously, 0 = stop and hold result
//   sig_in   in   1      signal under test, asynchronous to clk
//   counter  out  CNT_W  rising edges seen in the last complete window
//   valid    out  1      one-cycle pulse, 'counter' was updated this cycle
//   ovf      out  1      last complete window saturated at 2^CNT_W-1
// ---------------------------------------------------------------------------
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] counter,
    output logic             valid,
    output logic             ovf
);

    localparam int unsigned GATE_W  = $clog2(GATE_CYCLES);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic               prev_q, prev_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic               rise;
    logic [CNT_W:0]     edge_sum;
    logic               sat_hit;
    logic [CNT_W-1:0]   edge_sat;

    // Input path: synchronizer shift register followed by one edge-detect flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Saturating increment; the carry out marks an edge that could not be counted.
    always_comb begin
        edge_sum = {1'b0, edge_q} + {{CNT_W{1'b0}}, rise};
        sat_hit  = edge_sum[CNT_W];
        edge_sat = sat_hit ? {CNT_W{1'b1}} : edge_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        sat_d     = sat_q;
        counter_d = counter_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end
            end

            // Let the synchronizer refill with live data; edges are ignored here.
            FLUSH: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (flush_q == FLUSH_LAST) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end

            MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    // Window end latches even if enable drops this same cycle,
                    // and includes an edge arriving on this cycle.
                    counter_d = edge_sat;
                    ovf_d     = sat_q | sat_hit;
                    valid_d   = 1'b1;
                    gate_d    = '0;
                    edge_d    = '0;
                    sat_d     = 1'b0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    edge_d = edge_sat;
                    sat_d  = sat_q | sat_hit;
                end
                if (!enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving for IDLE throws away any partial window.
        if (state_d == IDLE) begin
            gate_d = '0;
            edge_d = '0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            flush_q   <= '0;
            gate_q    <= '0;
            edge_q    <= '0;
            sat_q     <= 1'b0;
            counter_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            flush_q   <= flush_d;
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            sat_q     <= sat_d;
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign counter = counter_q;
    assign valid   = valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_counter
//   Directed bench for freq_gate_counter with 100-cycle gate windows. Two
//   instances share all inputs: an 8-bit counter build and a 4-bit build used
//   for the saturation scenario.
// ---------------------------------------------------------------------------
module tb_freq_gate_counter;

    localparam int GATE = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] counter8;
    logic       valid8;
    logic       ovf8;
    logic [3:0] counter4;
    logic       valid4;
    logic       ovf4;

    int tests_run = 0;
    int tests_failed = 0;
    int ph = 0;
    int period = 0;

    always #5 clk = ~clk;

    freq_gate_counter #(.GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .counter(counter8), .valid(valid8), .ovf(ovf8)
    );

    freq_gate_counter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .counter(counter4), .valid(valid4), .ovf(ovf4)
    );

    // Advance one clock, land 1 ns after the edge, drive the square wave.
    task automatic tick();
        @(posedge clk);
        #1;
        ph++;
        if (period == 0) sig_in = 1'b0;
        else sig_in = ((ph % period) < (period / 2));
    endtask

    // Returns ticks until valid8 is seen, or -1 when the budget runs out.
    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (valid8 === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b0;
        enable = 1'b0;
        period = 2;
        ph = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (counter8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: cnt=%0d valid=%b ovf=%b, want 0/0/0", counter8, valid8, ovf8);
            end
        end
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (valid8 === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_disabled_valid: pulses=%0d, want 0", pulses);
        end
        tests_run++;
        if (counter8 !== 8'd0 || ovf8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_disabled_out: cnt=%0d ovf=%b, want 0/0", counter8, ovf8);
        end
        $display("[TB] reset: outputs cleared, no valid while disabled (%0d pulses)", pulses);
    endtask

    task automatic test_steady();
        int n;
        period = 10;
        ph = 0;
        enable = 1'b1;
        wait_valid(300, n);
        tests_run++;
        if (n !== 104) begin
            tests_failed++;
            $display("FAIL steady_first_latency: got %0d ticks, want 104", n);
        end
        for (int w = 2; w <= 4; w++) begin
            wait_valid(150, n);
            tests_run++;
            if (n !== GATE || counter8 !== 8'd10 || ovf8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL steady_window%0d: gap=%0d cnt=%0d ovf=%b, want 100/10/0", w, n, counter8, ovf8);
            end
            $display("[TB] steady window %0d: gap=%0d counter=%0d ovf=%b", w, n, counter8, ovf8);
        end
        tests_run++;
        if (counter4 !== 4'd10 || ovf4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL steady_cnt4: cnt=%0d ovf=%b, want 10/0", counter4, ovf4);
        end
    endtask

    task automatic test_boundary();
        int n;
        int starts [14] = '{10, 40, 97, 103, 150, 190, 198, 250, 295, 320, 397, 405, 460, 497};
        int exp_cnt [5] = '{3, 3, 3, 2, 3};
        int sum;
        bit hi;
        period = 0;
        wait_valid(150, n);
        wait_valid(150, n);
        tests_run++;
        if (n !== GATE) begin
            tests_failed++;
            $display("FAIL boundary_sync: gap=%0d, want 100", n);
        end
        // t counts ticks from the valid cycle, where gate_cnt is 0. A rise
        // driven at step t is counted at gate_cnt t+2, so t=97 lands on 99.
        sum = 0;
        for (int t = 1; t <= 500; t++) begin
            tick();
            if (t % GATE == 0) begin
                tests_run++;
                if (valid8 !== 1'b1 || counter8 !== 8'(exp_cnt[t / GATE - 1])) begin
                    tests_failed++;
                    $display("FAIL boundary_window%0d: valid=%b cnt=%0d, want 1/%0d",
                             t / GATE, valid8, counter8, exp_cnt[t / GATE - 1]);
                end
                $display("[TB] boundary window %0d: counter=%0d", t / GATE, counter8);
                sum += int'(counter8);
            end
            hi = 1'b0;
            foreach (starts[k]) if (t >= starts[k] && t <= starts[k] + 2) hi = 1'b1;
            sig_in = hi;
        end
        tests_run++;
        if (sum !== 14) begin
            tests_failed++;
            $display("FAIL boundary_sum: got %0d, want 14", sum);
        end
    endtask

    task automatic test_saturation();
        int n;
        period = 4;
        ph = 0;
        wait_valid(150, n);
        wait_valid(150, n);
        tests_run++;
        if (n !== GATE || counter4 !== 4'd15 || ovf4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_cnt4: gap=%0d cnt=%0d ovf=%b, want 100/15/1", n, counter4, ovf4);
        end
        tests_run++;
        if (counter8 !== 8'd25 || ovf8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_cnt8: cnt=%0d ovf=%b, want 25/0", counter8, ovf8);
        end
        $display("[TB] period 4: cnt4=%0d ovf4=%b cnt8=%0d", counter4, ovf4, counter8);
        period = 20;
        ph = 0;
        wait_valid(150, n);
        wait_valid(150, n);
        tests_run++;
        if (n !== GATE || counter4 !== 4'd5 || ovf4 !== 1'b0 || counter8 !== 8'd5) begin
            tests_failed++;
            $display("FAIL sat_recover: gap=%0d cnt4=%0d ovf4=%b cnt8=%0d, want 100/5/0/5",
                     n, counter4, ovf4, counter8);
        end
        $display("[TB] period 20: cnt4=%0d ovf4=%b cnt8=%0d", counter4, ovf4, counter8);
    endtask

    task automatic test_enable_drop();
        int n;
        int pulses;
        int changed;
        period = 10;
        ph = 0;
        wait_valid(150, n);
        wait_valid(150, n);
        tests_run++;
        if (counter8 !== 8'd10) begin
            tests_failed++;
            $display("FAIL drop_before: cnt=%0d, want 10", counter8);
        end
        for (int i = 0; i < 50; i++) tick();
        enable = 1'b0;
        pulses = 0;
        changed = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (valid8 === 1'b1) pulses++;
            if (counter8 !== 8'd10) changed++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL drop_valid: pulses=%0d, want 0", pulses);
        end
        tests_run++;
        if (changed !== 0) begin
            tests_failed++;
            $display("FAIL drop_hold: counter changed on %0d cycles, want 0", changed);
        end
        enable = 1'b1;
        wait_valid(200, n);
        tests_run++;
        if (n !== 104 || counter8 !== 8'd10) begin
            tests_failed++;
            $display("FAIL drop_reenable: ticks=%0d cnt=%0d, want 104/10", n, counter8);
        end
        $display("[TB] enable drop: pulses=%0d reenable ticks=%0d counter=%0d", pulses, n, counter8);
    endtask

    task automatic test_async_reset();
        int n;
        period = 10;
        wait_valid(150, n);
        for (int i = 0; i < 60; i++) tick();
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (counter8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0 || counter4 !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_clear: cnt=%0d valid=%b ovf=%b cnt4=%0d, want 0/0/0/0",
                     counter8, valid8, ovf8, counter4);
        end
        tick();
        tick();
        rst = 1'b1;
        wait_valid(200, n);
        tests_run++;
        if (n !== 104 || counter8 !== 8'd10 || ovf8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_restart: ticks=%0d cnt=%0d ovf=%b, want 104/10/0", n, counter8, ovf8);
        end
        $display("[TB] async reset: restart ticks=%0d counter=%0d", n, counter8);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_boundary();
        test_saturation();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
